// File: rtl/rf_wr_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : rf_wr_arbiter
// Purpose  : Round-robin arbiter that merges NUM_REQ register-file write
//            requesters onto a single registered write port. Writes to
//            address 0 can be accepted but suppressed (hardwired x0).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
module rf_wr_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_WIDTH   = 5,
    parameter int DATA_WIDTH   = 32,
    parameter int ZERO_DISCARD = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            hold,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic                            wr_en,
    output logic [ADDR_WIDTH-1:0]           wr_addr,
    output logic [DATA_WIDTH-1:0]           wr_data,
    output logic [$clog2(NUM_REQ)-1:0]      grant_idx,
    output logic [15:0]                     xfer_count
);

    localparam int IDX_W = $clog2(NUM_REQ);

    // Priority pointer and registered write port
    logic [IDX_W-1:0]       ptr_q,       ptr_d;
    logic                   wr_en_q,     wr_en_d;
    logic [ADDR_WIDTH-1:0]  wr_addr_q,   wr_addr_d;
    logic [DATA_WIDTH-1:0]  wr_data_q,   wr_data_d;
    logic [IDX_W-1:0]       grant_q,     grant_d;
    logic [15:0]            count_q,     count_d;

    // Arbitration results
    logic                   w_found;
    logic [IDX_W-1:0]       w_win;
    logic [IDX_W:0]         w_cand;
    logic [IDX_W-1:0]       w_cand_idx;
    logic                   w_xfer;
    logic [ADDR_WIDTH-1:0]  w_sel_addr;
    logic [DATA_WIDTH-1:0]  w_sel_data;
    logic [IDX_W:0]         w_ptr_inc;

    // Cyclic search for the first valid requester starting at ptr_q; the
    // candidate index is reduced modulo NUM_REQ so non power-of-two counts work.
    always_comb begin
        w_found    = 1'b0;
        w_win      = '0;
        w_cand     = '0;
        w_cand_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, ptr_q} + (IDX_W+1)'(k);
            if (w_cand >= (IDX_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (IDX_W+1)'(NUM_REQ);
            end
            w_cand_idx = w_cand[IDX_W-1:0];
            if (!w_found && req_valid[w_cand_idx]) begin
                w_found = 1'b1;
                w_win   = w_cand_idx;
            end
        end
    end

    // Ready is the one-hot winner, gated by hold and reset; address/data never
    // influence it so requesters see a stable handshake.
    always_comb begin
        req_ready = '0;
        if (w_found && !hold && rst_n) begin
            req_ready[w_win] = 1'b1;
        end
    end

    assign w_xfer     = w_found & ~hold & rst_n;
    assign w_sel_addr = req_addr[w_win*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_sel_data = req_data[w_win*DATA_WIDTH +: DATA_WIDTH];

    // Next-state of the write port, pointer and transfer counter
    always_comb begin
        w_ptr_inc = {1'b0, w_win} + {{IDX_W{1'b0}}, 1'b1};
        if (w_ptr_inc >= (IDX_W+1)'(NUM_REQ)) begin
            w_ptr_inc = '0;
        end
        ptr_d     = ptr_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        grant_d   = grant_q;
        count_d   = count_q;
        if (w_xfer) begin
            ptr_d     = w_ptr_inc[IDX_W-1:0];
            wr_en_d   = !((ZERO_DISCARD != 0) && (w_sel_addr == '0));
            wr_addr_d = w_sel_addr;
            wr_data_d = w_sel_data;
            grant_d   = w_win;
            count_d   = count_q + 16'd1;
        end
    end

    // State registers with asynchronous clear; reset drops any pending write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            grant_q   <= '0;
            count_q   <= '0;
        end else begin
            ptr_q     <= ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            grant_q   <= grant_d;
            count_q   <= count_d;
        end
    end

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign grant_idx  = grant_q;
    assign xfer_count = count_q;

endmodule
`default_nettype wire

// File: doc/rf_wr_arbiter.md
RF_WR_ARBITER -- requirements
Module: rf_wr_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, meaning the number of requesters (range 2..8).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 5, meaning the register-file address width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32, meaning the write data width.
REQ-004 The block SHALL have parameter ZERO_DISCARD, default 1, meaning writes to address 0 are accepted but suppressed (x0 hardwired).
REQ-005 The block SHALL have port clk  input  1  clock, rising-edge.
REQ-006 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 The block SHALL have port hold  input  1  freezes arbitration, so no grants are issued.
REQ-008 The block SHALL have port req_valid  input  NUM_REQ  per-requester write request.
REQ-009 The block SHALL have port req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses, requester i at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-010 The block SHALL have port req_data  input  NUM_REQ*DATA_WIDTH  packed data, same slicing rule.
REQ-011 The block SHALL have port req_ready  output  NUM_REQ  per-requester accept, combinational.
REQ-012 The block SHALL have port wr_en  output  1  register-file write enable, registered.
REQ-013 The block SHALL have port wr_addr  output  ADDR_WIDTH  write address, registered.
REQ-014 The block SHALL have port wr_data  output  DATA_WIDTH  write data, registered.
REQ-015 The block SHALL have port grant_idx  output  $clog2(NUM_REQ)  index of the last accepted requester, registered.
REQ-016 The block SHALL have port xfer_count  output  16  count of accepted transfers, wrapping.

Function
REQ-017 The arbiter SHALL select the winner as the first requester with req_valid=1, searching cyclically from priority pointer ptr (ptr, ptr+1, ... mod NUM_REQ).
REQ-018 req_ready SHALL be one-hot or zero: only the winner's bit is 1, and all bits are 0 when hold=1 or no req_valid is set.
REQ-019 A transfer SHALL occur on a rising edge where req_valid[i]=1 and req_ready[i]=1.
REQ-020 req_ready SHALL depend only on req_valid, ptr and hold, never on req_addr or req_data.
REQ-021 On a transfer from requester i, ptr SHALL become (i+1) mod NUM_REQ at the same edge; without a transfer, ptr SHALL be unchanged.
REQ-022 On a transfer, the next cycle SHALL present wr_addr = req_addr[i], wr_data = req_data[i], grant_idx = i and wr_en = 1, giving a latency of exactly 1 cycle.
REQ-023 When ZERO_DISCARD=1 and the transferred address is 0, the transfer SHALL complete (ready high, ptr advances, xfer_count increments) but wr_en SHALL be 0 in the next cycle.
REQ-024 In a cycle with no transfer, wr_en SHALL be 0 in the next cycle, and wr_addr, wr_data and grant_idx SHALL hold their previous values.
REQ-025 The block SHALL sustain back-to-back transfers, one per cycle, with no bubble.
REQ-026 xfer_count SHALL increment by 1 per transfer and wrap from 16'hFFFF to 0.
REQ-027 Asserting hold SHALL block new grants in that same cycle; a write already registered SHALL still appear on wr_en in the following cycle.
REQ-028 Requester inputs SHALL be allowed to change when not granted; a dropped req_valid SHALL leave ptr unaffected.

Reset
REQ-029 While rst_n=0, and asynchronously on its falling edge, the block SHALL force wr_en=0, wr_addr=0, wr_data=0, grant_idx=0, xfer_count=0 and ptr=0.
REQ-030 req_ready SHALL be all 0 while rst_n=0.
REQ-031 Reset asserted mid-stream SHALL discard any pending registered write: wr_en=0 in the reset cycle, with no partial writes.
REQ-032 The first transfer after reset release SHALL use ptr=0.

Verification
REQ-033 The bench SHALL cover: reset, then req_valid=4'b1111 held for 8 cycles -> grants 0,1,2,3,0,1,2,3; wr_en=1 for 8 consecutive cycles; xfer_count=8.
REQ-034 The bench SHALL cover: only req_valid[2] with addr=5'd7 and data=32'hDEADBEEF -> req_ready=4'b0100; next cycle wr_en=1, wr_addr=7, wr_data=32'hDEADBEEF, grant_idx=2.
REQ-035 The bench SHALL cover: requester 1 with addr=0 and ZERO_DISCARD=1 -> req_ready[1]=1, wr_en=0 next cycle, xfer_count increments, ptr=2.
REQ-036 The bench SHALL cover: hold=1 with req_valid=4'b1010 for 3 cycles -> req_ready=0 and wr_en=0 throughout; on hold release, requester 1 is granted first (ptr=0).
REQ-037 The bench SHALL cover: preload xfer_count to 16'hFFFF via 65535 transfers, then one more transfer -> xfer_count=0.
REQ-038 The bench SHALL cover: rst_n pulsed low for 1 cycle during continuous traffic -> all outputs are 0 immediately; after release, the grant order restarts at requester 0.
